// File: rtl/dmem_write_arbiter.sv
// Data-memory write-port arbiter: core stores are posted through a small FIFO,
// a secondary master writes directly, and the winner drives a registered write port.
module dmem_write_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     core_valid,
  output logic                     core_ready,
  input  logic [31:0]              core_addr,
  input  logic [31:0]              core_data,
  input  logic [3:0]               core_wmask,
  input  logic                     dma_valid,
  output logic                     dma_ready,
  input  logic [31:0]              dma_addr,
  input  logic [31:0]              dma_data,
  input  logic [3:0]               dma_wmask,
  input  logic                     mem_stall,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_din,
  output logic [3:0]               mem_we,
  output logic                     store_pending,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 2);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } wr_t;

  wr_t           r_fifo [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_starve;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_mem_din;
  logic [3:0]    r_mem_we;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_starved;
  logic w_grant_dma;
  wr_t  w_head;
  wr_t  w_core_wr;

  always_comb begin
    w_full      = (r_count == CW'(DEPTH));
    w_empty     = (r_count == '0);
    // Zero-mask stores complete the handshake but never occupy a slot.
    w_push      = core_valid && !w_full && (core_wmask != '0);
    w_starved   = (r_starve == SW'(STARVE_LIMIT));
    w_grant_dma = !mem_stall && dma_valid && (w_empty || w_starved);
    w_pop       = !mem_stall && !w_grant_dma && !w_empty;
    w_head      = r_fifo[r_rd_ptr];
    w_core_wr   = '{addr: core_addr, data: core_data, mask: core_wmask};
  end

  // Storage carries no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= w_core_wr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Stalled cycles are not counted as denials: the port was unavailable to everyone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (!dma_valid || w_grant_dma) begin
      r_starve <= '0;
    end else if (!mem_stall && !w_starved) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_mem_we   <= '0;
    end else if (w_grant_dma) begin
      r_mem_addr <= dma_addr;
      r_mem_din  <= dma_data;
      r_mem_we   <= dma_wmask;
    end else if (w_pop) begin
      r_mem_addr <= w_head.addr;
      r_mem_din  <= w_head.data;
      r_mem_we   <= w_head.mask;
    end else begin
      r_mem_we   <= '0;
    end
  end

  always_comb begin
    core_ready    = !w_full;
    dma_ready     = w_grant_dma;
    mem_addr      = r_mem_addr;
    mem_din       = r_mem_din;
    mem_we        = r_mem_we;
    store_pending = !w_empty || (r_mem_we != '0);
    fifo_count    = r_count;
  end

endmodule

// File: tb/tb_dmem_write_arbiter.sv
// Bench for dmem_write_arbiter: per-cycle vector table plus reset sequences; every
// memory write is matched against a per-requester scoreboard queue.
module tb_dmem_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        core_valid;
  logic        core_ready;
  logic [31:0] core_addr;
  logic [31:0] core_data;
  logic [3:0]  core_wmask;
  logic        dma_valid;
  logic        dma_ready;
  logic [31:0] dma_addr;
  logic [31:0] dma_data;
  logic [3:0]  dma_wmask;
  logic        mem_stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [3:0]  mem_we;
  logic        store_pending;
  logic [2:0]  fifo_count;

  dmem_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_valid(core_valid), .core_ready(core_ready),
    .core_addr(core_addr), .core_data(core_data), .core_wmask(core_wmask),
    .dma_valid(dma_valid), .dma_ready(dma_ready),
    .dma_addr(dma_addr), .dma_data(dma_data), .dma_wmask(dma_wmask),
    .mem_stall(mem_stall),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .store_pending(store_pending), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } wr_t;

  typedef struct {
    bit       cv;
    bit [3:0] cmask;
    bit       dv;
    bit [3:0] dmask;
    bit       stall;
    bit       exp_cr;
    bit       exp_dr;
    int       exp_cnt;
    bit [3:0] exp_we;
    bit       exp_pend;
  } vec_t;

  wr_t  core_q[$];
  wr_t  dma_q[$];
  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   core_id = 0;
  int   dma_id = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic add(input bit cv, input bit [3:0] cmask, input bit dv, input bit [3:0] dmask,
                     input bit stall, input bit exp_cr, input bit exp_dr, input int exp_cnt,
                     input bit [3:0] exp_we, input bit exp_pend);
    vec_t v;
    v.cv = cv; v.cmask = cmask; v.dv = dv; v.dmask = dmask; v.stall = stall;
    v.exp_cr = exp_cr; v.exp_dr = exp_dr; v.exp_cnt = exp_cnt;
    v.exp_we = exp_we; v.exp_pend = exp_pend;
    vecs.push_back(v);
  endtask

  task automatic apply_row(input int idx, input vec_t v);
    @(posedge clk); #1;
    core_valid = v.cv;
    core_addr  = 32'h1000_0100 + 32'(core_id) * 4;
    core_data  = 32'hC0DE_0000 + 32'(core_id);
    core_wmask = v.cmask;
    dma_valid  = v.dv;
    dma_addr   = 32'h8000_0040 + 32'(dma_id) * 4;
    dma_data   = 32'hD000_0000 + 32'(dma_id);
    dma_wmask  = v.dmask;
    mem_stall  = v.stall;
    #1;
    chk($sformatf("row%0d_core_ready", idx), 32'(core_ready), 32'(v.exp_cr));
    chk($sformatf("row%0d_dma_ready", idx), 32'(dma_ready), 32'(v.exp_dr));
    chk($sformatf("row%0d_fifo_count", idx), 32'(fifo_count), 32'(v.exp_cnt));
    chk($sformatf("row%0d_mem_we", idx), 32'(mem_we), 32'(v.exp_we));
    chk($sformatf("row%0d_store_pending", idx), 32'(store_pending), 32'(v.exp_pend));
    if (v.cv && v.exp_cr && v.cmask != 4'h0) core_q.push_back({core_addr, core_data, core_wmask});
    if (v.dv && v.exp_dr) begin
      dma_q.push_back({dma_addr, dma_data, dma_wmask});
      dma_id++;
    end
    if (v.cv) core_id++;
  endtask

  // Write monitor: DMA traffic lives in the upper half of the address map.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("fifo_count_bound", 32'(fifo_count <= 3'd4), 32'd1);
      if (mem_we != 4'h0) begin
        wr_t got;
        wr_t exp;
        got = {mem_addr, mem_din, mem_we};
        if (mem_addr[31]) begin
          if (dma_q.size() == 0) begin
            chk("dma_wr_unexpected", mem_addr, 32'h0);
          end else begin
            exp = dma_q.pop_front();
            chk("dma_wr_addr", got.a, exp.a);
            chk("dma_wr_data", got.d, exp.d);
            chk("dma_wr_mask", 32'(got.m), 32'(exp.m));
          end
        end else begin
          if (core_q.size() == 0) begin
            chk("core_wr_unexpected", mem_addr, 32'h8000_0000);
          end else begin
            exp = core_q.pop_front();
            chk("core_wr_addr", got.a, exp.a);
            chk("core_wr_data", got.d, exp.d);
            chk("core_wr_mask", 32'(got.m), 32'(exp.m));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    core_valid = 1'b1; core_addr = 32'h1000_0004; core_data = 32'hAABB_CCDD; core_wmask = 4'hF;
    dma_valid = 1'b0; dma_addr = '0; dma_data = '0; dma_wmask = '0;
    mem_stall = 1'b0;

    // Reset with a store already requested, then the first-store latency.
    @(posedge clk); @(posedge clk); #1;
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_fifo_count", 32'(fifo_count), 32'h0);
    chk("rst_core_ready", 32'(core_ready), 32'h1);
    chk("rst_store_pending", 32'(store_pending), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("t1_core_ready", 32'(core_ready), 32'h1);
    core_q.push_back({32'h1000_0004, 32'hAABB_CCDD, 4'hF});
    @(posedge clk); #1;
    core_valid = 1'b0;
    #1;
    chk("t1_we_n1", 32'(mem_we), 32'h0);
    chk("t1_count_n1", 32'(fifo_count), 32'h1);
    @(posedge clk); #2;
    chk("t1_we_n2", 32'(mem_we), 32'hF);
    chk("t1_addr_n2", mem_addr, 32'h1000_0004);
    chk("t1_din_n2", mem_din, 32'hAABB_CCDD);
    @(posedge clk); #2;
    chk("t1_we_n3", 32'(mem_we), 32'h0);
    chk("t1_pend_n3", 32'(store_pending), 32'h0);

    // Fill under stall, fifth store refused, then in-order drain.
    add(1, 4'hF, 0, 0, 1, 1, 0, 0, 4'h0, 0);
    add(1, 4'h3, 0, 0, 1, 1, 0, 1, 4'h0, 1);
    add(1, 4'hC, 0, 0, 1, 1, 0, 2, 4'h0, 1);
    add(1, 4'h1, 0, 0, 1, 1, 0, 3, 4'h0, 1);
    add(1, 4'h8, 0, 0, 1, 0, 0, 4, 4'h0, 1);
    add(0, 4'h0, 0, 0, 0, 0, 0, 4, 4'h0, 1);
    add(0, 4'h0, 0, 0, 0, 1, 0, 3, 4'hF, 1);
    add(0, 4'h0, 0, 0, 0, 1, 0, 2, 4'h3, 1);
    add(0, 4'h0, 0, 0, 0, 1, 0, 1, 4'hC, 1);
    add(0, 4'h0, 0, 0, 0, 1, 0, 0, 4'h1, 1);
    add(0, 4'h0, 0, 0, 0, 1, 0, 0, 4'h0, 0);
    // Starvation: forced grant on the 9th waiting cycle, then the guard restarts from zero.
    add(1, 4'hF, 0, 0, 0, 1, 0, 0, 4'h0, 0);
    for (int j = 1; j <= 8; j++) add(1, 4'hF, 1, 4'h6, 0, 1, 0, 1, (j == 1) ? 4'h0 : 4'hF, 1);
    add(1, 4'hF, 1, 4'h6, 0, 1, 1, 1, 4'hF, 1);
    add(0, 4'h0, 1, 4'h6, 0, 1, 0, 2, 4'h6, 1);
    add(0, 4'h0, 1, 4'h6, 0, 1, 0, 1, 4'hF, 1);
    add(0, 4'h0, 1, 4'h6, 0, 1, 1, 0, 4'hF, 1);
    add(0, 4'h0, 0, 0, 0, 1, 0, 0, 4'h6, 1);
    add(0, 4'h0, 0, 0, 0, 1, 0, 0, 4'h0, 0);
    // DMA into an idle port alongside a core push.
    add(1, 4'hF, 1, 4'h9, 0, 1, 1, 0, 4'h0, 0);
    add(0, 4'h0, 0, 0, 0, 1, 0, 1, 4'h9, 1);
    add(0, 4'h0, 0, 0, 0, 1, 0, 0, 4'hF, 1);
    add(0, 4'h0, 0, 0, 0, 1, 0, 0, 4'h0, 0);
    // Zero-mask store is a no-op.
    add(1, 4'h0, 0, 0, 0, 1, 0, 0, 4'h0, 0);
    add(0, 4'h0, 0, 0, 0, 1, 0, 0, 4'h0, 0);
    add(0, 4'h0, 0, 0, 0, 1, 0, 0, 4'h0, 0);

    for (int i = 0; i < vecs.size(); i++) apply_row(i, vecs[i]);

    chk("pre_rst_core_q_empty", 32'(core_q.size()), 32'h0);
    chk("pre_rst_dma_q_empty", 32'(dma_q.size()), 32'h0);

    // Asynchronous reset with stores buffered and a write in flight; nothing may drain afterwards.
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      core_valid = 1'b1;
      core_addr  = 32'h1000_0200 + 32'(k) * 4;
      core_data  = 32'hDEAD_0000 + 32'(k);
      core_wmask = 4'hF;
      dma_valid  = 1'b0;
      mem_stall  = (k < 3);
    end
    @(posedge clk); #1;
    core_valid = 1'b0;
    mem_stall  = 1'b1;
    #1;
    chk("t6_count_before", 32'(fifo_count), 32'h3);
    chk("t6_we_before", 32'(mem_we), 32'hF);
    chk("t6_addr_before", mem_addr, 32'h1000_0200);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_we", 32'(mem_we), 32'h0);
    chk("t6_rst_addr", mem_addr, 32'h0);
    chk("t6_rst_din", mem_din, 32'h0);
    chk("t6_rst_count", 32'(fifo_count), 32'h0);
    chk("t6_rst_pend", 32'(store_pending), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    mem_stall = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #2;
      chk($sformatf("t6_post_we%0d", k), 32'(mem_we), 32'h0);
      chk($sformatf("t6_post_count%0d", k), 32'(fifo_count), 32'h0);
      chk($sformatf("t6_post_pend%0d", k), 32'(store_pending), 32'h0);
    end

    chk("end_core_q_empty", 32'(core_q.size()), 32'h0);
    chk("end_dma_q_empty", 32'(dma_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/dmem_write_arbiter.md
Name: dmem_write_arbiter

Overview:
- Shares the single data-memory write port between two requesters: core stores and a secondary bus master (DMA/bootloader fill).
- Core stores arrive already lane-shifted, with a byte-enable mask from the core's store-formatting logic.
- Core stores are posted into a small FIFO so the pipeline does not stall on port contention.
- Arbitration gives the core priority, with a starvation guard for the secondary master; the output is a registered BRAM-style write port.

Parameters:
- DEPTH, 4: core store FIFO entries (power of two, >=2).
- STARVE_LIMIT, 8: consecutive denied cycles of a pending DMA request before the DMA master is forced a grant.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- core_valid  in  1  core store request
- core_ready  out  1  FIFO can accept; equals !full
- core_addr  in  32  word address of store
- core_data  in  32  lane-aligned store data
- core_wmask  in  4  byte enables
- dma_valid  in  1  secondary write request
- dma_ready  out  1  combinational grant to the secondary master this cycle
- dma_addr  in  32  write address
- dma_data  in  32  write data
- dma_wmask  in  4  byte enables
- mem_stall  in  1  write port unavailable this cycle
- mem_addr  out  32  registered write address
- mem_din  out  32  registered write data
- mem_we  out  4  registered byte write enables; 0 means no write
- store_pending  out  1  FIFO non-empty or mem_we != 0; the core holds loads while this is high
- fifo_count  out  $clog2(DEPTH)+1  number of occupied FIFO entries

Behaviour:
- Reset (async, rst_n=0):
  - FIFO pointers and count go to 0; the starvation counter goes to 0.
  - mem_addr, mem_din and mem_we all go to 0; store_pending goes to 0.
  - Buffered stores are discarded, including on reset mid-operation.
- Enqueue:
  - A core transfer occurs when core_valid && core_ready.
  - Transfers with core_wmask==0 are accepted but not stored (a no-op store).
  - core_ready is !full only; a same-cycle dequeue does not free a slot for that cycle's enqueue.
- Grant decision (combinational, each cycle; no grant when mem_stall=1):
  - If FIFO is empty and dma_valid: grant DMA.
  - If starve_cnt==STARVE_LIMIT and dma_valid: grant DMA.
  - Otherwise, if FIFO is non-empty: grant FIFO head (pop).
  - Otherwise: no grant.
- dma_ready equals the DMA grant; the DMA transfer completes in that cycle. The DMA master holds its payload stable while dma_valid && !dma_ready.
- Output register, at each edge:
  - On a grant, load the granted addr/data/mask.
  - Otherwise, load mem_we=0; addr and data hold their previous values.
  - mem_we is therefore high for exactly one cycle per granted write.
- Latency:
  - Core store accepted in cycle N, FIFO empty, no contention: head valid N+1, granted N+1, mem_we asserted N+2.
  - DMA granted in cycle N: mem_we asserted N+1.
- Starvation counter (saturating at STARVE_LIMIT):
  - Increments each cycle dma_valid && !dma_ready.
  - Clears on a DMA grant or when dma_valid=0.
  - While mem_stall=1, it holds its value rather than incrementing.
- Ordering:
  - Core stores issue strictly in FIFO order.
  - No ordering is guaranteed between core and DMA writes to the same address; software partitions the regions.
- Count:
  - Push only: +1. Pop only: -1. Push and pop together: unchanged.
  - Pop never occurs when empty; push never occurs when full.
- store_pending is combinational from count and mem_we.
- Overflow or underflow is impossible by construction; the bench asserts on it.

Test Plan:
1. Reset with core_valid=1 asserted, then release rst_n. Required: mem_we=0, fifo_count=0, core_ready=1. First store (addr 0x10000004, data 0xAABBCCDD, mask 4'b1111) shows mem_we=4'b1111 exactly 2 cycles after acceptance.
2. Hold mem_stall=1 and issue 5 core stores with DEPTH=4. Required: 4 accepted, core_ready=0 and fifo_count=4 on the 5th. Release stall. Required: the writes drain in order on 4 consecutive cycles and fifo_count reaches 0.
3. Keep the core FIFO non-empty continuously while dma_valid=1 with STARVE_LIMIT=8. Required: dma_ready rises on the 9th cycle of waiting, then the counter clears and the core resumes.
4. Assert dma_valid with the FIFO empty. Required: dma_ready=1 in the same cycle and mem_we=dma_wmask the next cycle. A simultaneous core push is queued and written one cycle later.
5. Send a core store with wmask 4'b0000. Required: accepted, fifo_count unchanged, no mem_we pulse, store_pending stays 0.
6. Pull rst_n low with 3 stores buffered and mem_we active. Required: all outputs 0 immediately (asynchronous), buffered stores never written after reset release.
